rggen_rwl_lock_controller: RTL and testbench

Key-sequenced lock controller that drives the `i_lock` input of one or more lock-protected read/write bit fields. Software must write a two-word key sequence to a key register before protected fields accept writes. Protection reopens only for a bounded window, and optionally for only one protected write. It sits beside the register block and feeds its `o_lock` output directly to the protected bit fields.

---
 rtl/rggen_rwl_lock_pkg.sv | 15 +
 rtl/rggen_rwl_lock_timer.sv | 29 ++
 rtl/rggen_rwl_lock_controller.sv | 111 +++++++++++
 tb/tb_rggen_rwl_lock_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_rwl_lock_pkg.sv
// Shared types and helpers for the key-sequenced lock controller.
package rggen_rwl_lock_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        ARMED    = 2'd1,
        UNLOCKED = 2'd2
    } rggen_rwl_lock_state_e;

    // Counter must be able to hold TIMEOUT-1 down to 0.
    function automatic int clog2_timeout(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rggen_rwl_lock_timer.sv
// Loadable down-counter; saturates at zero, clear beats load beats decrement.
module rggen_rwl_lock_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    input  logic          clear,
    output logic [CW-1:0] count,
    output logic          zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rggen_rwl_lock_controller.sv
// Two-word key sequence opens a bounded write window for lock-protected fields.
module rggen_rwl_lock_controller
    import rggen_rwl_lock_pkg::*;
#(
    parameter int                   KEY_WIDTH       = 8,
    parameter logic [KEY_WIDTH-1:0] KEY0            = 8'hA5,
    parameter logic [KEY_WIDTH-1:0] KEY1            = 8'h5A,
    parameter int                   TIMEOUT         = 16,
    parameter bit                   RELOCK_ON_WRITE = 1'b1,
    parameter int                   CW              = clog2_timeout(TIMEOUT)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_key_valid,
    input  logic [KEY_WIDTH-1:0] i_key_data,
    input  logic                 i_guarded_write,
    input  logic                 i_force_lock,
    output logic                 o_lock,
    output logic                 o_key_error,
    output logic [CW-1:0]        o_remaining
);

    localparam logic [CW-1:0] LOAD_VALUE = CW'(TIMEOUT - 1);

    rggen_rwl_lock_state_e state, next_state;
    logic          load, dec, clear, key_error_next, zero;
    logic [CW-1:0] count;

    rggen_rwl_lock_timer #(.CW(CW)) u_timer (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .load       (load),
        .load_value (LOAD_VALUE),
        .dec        (dec),
        .clear      (clear),
        .count      (count),
        .zero       (zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= LOCKED;
            o_key_error <= 1'b0;
        end else begin
            state       <= next_state;
            o_key_error <= key_error_next;
        end
    end

    always_comb begin
        next_state     = state;
        load           = 1'b0;
        dec            = 1'b0;
        clear          = 1'b0;
        key_error_next = 1'b0;
        case (state)
            LOCKED: begin
                if (i_key_valid) begin
                    if (i_key_data == KEY0) begin
                        next_state = ARMED;
                        load       = 1'b1;
                    end else begin
                        key_error_next = 1'b1;
                    end
                end
            end
            ARMED: begin
                // A key arriving on the expiry cycle is still evaluated.
                if (i_key_valid) begin
                    if (i_key_data == KEY1) begin
                        next_state = UNLOCKED;
                        load       = 1'b1;
                    end else begin
                        next_state     = LOCKED;
                        clear          = 1'b1;
                        key_error_next = 1'b1;
                    end
                end else if (zero) begin
                    next_state = LOCKED;
                    clear      = 1'b1;
                end else begin
                    dec = 1'b1;
                end
            end
            UNLOCKED: begin
                // Any key write while open is a software re-lock, not an error.
                if (i_key_valid || (i_guarded_write && RELOCK_ON_WRITE) || zero) begin
                    next_state = LOCKED;
                    clear      = 1'b1;
                end else begin
                    dec = 1'b1;
                end
            end
            default: begin
                next_state = LOCKED;
                clear      = 1'b1;
            end
        endcase
        if (i_force_lock) begin
            next_state     = LOCKED;
            load           = 1'b0;
            dec            = 1'b0;
            clear          = 1'b1;
            key_error_next = 1'b0;
        end
    end

    assign o_lock      = (state != UNLOCKED);
    assign o_remaining = (state == UNLOCKED) ? count : '0;

endmodule

// File: tb/tb_rggen_rwl_lock_controller.sv
// Directed bench: two DUTs (relock-on-write on/off) against a deadline-based model.
module tb_rggen_rwl_lock_controller;

    localparam int          T    = 16;
    localparam int          CW   = $clog2(T + 1);
    localparam logic [7:0]  KEY0 = 8'hA5;
    localparam logic [7:0]  KEY1 = 8'h5A;

    logic          i_clk, i_rst_n, i_key_valid, i_guarded_write, i_force_lock;
    logic [7:0]    i_key_data;
    logic          lock_a, err_a, lock_b, err_b;
    logic [CW-1:0] rem_a, rem_b;

    int checks = 0;
    int errors = 0;

    // Model: absolute edge numbers at which the armed / unlocked windows end.
    int cyc;
    int armed_end  [2];
    int unlock_end [2];
    bit err_exp    [2];

    rggen_rwl_lock_controller #(.TIMEOUT(T), .RELOCK_ON_WRITE(1'b1)) u_dut_a (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_key_valid(i_key_valid), .i_key_data(i_key_data),
        .i_guarded_write(i_guarded_write), .i_force_lock(i_force_lock),
        .o_lock(lock_a), .o_key_error(err_a), .o_remaining(rem_a)
    );

    rggen_rwl_lock_controller #(.TIMEOUT(T), .RELOCK_ON_WRITE(1'b0)) u_dut_b (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_key_valid(i_key_valid), .i_key_data(i_key_data),
        .i_guarded_write(i_guarded_write), .i_force_lock(i_force_lock),
        .o_lock(lock_b), .o_key_error(err_b), .o_remaining(rem_b)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int i = 0; i < 2; i++) begin
            armed_end[i]  = 0;
            unlock_end[i] = 0;
            err_exp[i]    = 1'b0;
        end
    endtask

    task automatic model_edge(input bit kv, input logic [7:0] kd, input bit gw, input bit fl);
        int n;
        bit unl, arm;
        n = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            unl = unlock_end[i] > cyc;
            arm = armed_end[i] > cyc;
            err_exp[i] = 1'b0;
            if (fl) begin
                armed_end[i]  = 0;
                unlock_end[i] = 0;
            end else if (kv) begin
                if (unl) begin
                    unlock_end[i] = 0;
                end else if (arm) begin
                    armed_end[i] = 0;
                    if (kd == KEY1) unlock_end[i] = n + T;
                    else            err_exp[i] = 1'b1;
                end else begin
                    if (kd == KEY0) armed_end[i] = n + T;
                    else            err_exp[i] = 1'b1;
                end
            end else if (gw && (i == 0) && unl) begin
                unlock_end[i] = 0;
            end
        end
        cyc = n;
    endtask

    task automatic compare_all();
        int exp_rem;
        bit unl;
        for (int i = 0; i < 2; i++) begin
            unl     = unlock_end[i] > cyc;
            exp_rem = unl ? unlock_end[i] - 1 - cyc : 0;
            if (i == 0) begin
                check("lock_a", int'(lock_a), int'(!unl));
                check("rem_a",  int'(rem_a),  exp_rem);
                check("err_a",  int'(err_a),  int'(err_exp[0]));
            end else begin
                check("lock_b", int'(lock_b), int'(!unl));
                check("rem_b",  int'(rem_b),  exp_rem);
                check("err_b",  int'(err_exp[1]) == 0 ? int'(err_b) : int'(err_b), int'(err_exp[1]));
            end
        end
    endtask

    task automatic step(input bit kv, input logic [7:0] kd, input bit gw, input bit fl);
        i_key_valid     = kv;
        i_key_data      = kd;
        i_guarded_write = gw;
        i_force_lock    = fl;
        model_edge(kv, kd, gw, fl);
        @(posedge i_clk);
        #1;
        i_key_valid     = 1'b0;
        i_key_data      = 8'h00;
        i_guarded_write = 1'b0;
        i_force_lock    = 1'b0;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic key(input logic [7:0] kd);
        step(1'b1, kd, 1'b0, 1'b0);
    endtask

    initial begin
        i_rst_n = 1'b0; i_key_valid = 1'b0; i_key_data = 8'h00;
        i_guarded_write = 1'b0; i_force_lock = 1'b0;
        model_reset();
        #12 i_rst_n = 1'b1;
        check("reset_lock", int'(lock_a), 1);
        check("reset_rem",  int'(rem_a),  0);
        check("reset_err",  int'(err_a),  0);
        idle(2);

        // Basic unlock and natural expiry
        key(KEY0);
        key(KEY1);
        check("unlock_lock", int'(lock_a), 0);
        check("unlock_rem",  int'(rem_a),  15);
        idle(15);
        check("last_open_lock", int'(lock_a), 0);
        check("last_open_rem",  int'(rem_a),  0);
        idle(1);
        check("expired_lock", int'(lock_a), 1);

        // Wrong keys
        key(8'h33);
        check("bad_key_err", int'(err_a), 1);
        idle(1);
        check("err_one_cycle", int'(err_a), 0);
        key(KEY0);
        key(8'h00);
        check("bad_key1_err",  int'(err_a),  1);
        check("bad_key1_lock", int'(lock_a), 1);
        idle(1);

        // Armed window expiry: silent return to LOCKED, late KEY1 is just a wrong key
        key(KEY0);
        idle(T);
        check("armed_expired_err", int'(err_a), 0);
        key(KEY1);
        check("late_key1_lock", int'(lock_a), 1);
        idle(1);

        // KEY1 on the expiry cycle still unlocks, then key write re-locks silently
        key(KEY0);
        idle(T - 1);
        key(KEY1);
        check("edge_key1_lock", int'(lock_a), 0);
        check("edge_key1_rem",  int'(rem_a),  15);
        key(KEY0);
        check("sw_relock_lock", int'(lock_a), 1);
        check("sw_relock_err",  int'(err_a),  0);
        idle(1);

        // Guarded write at remaining=9
        key(KEY0);
        key(KEY1);
        idle(6);
        check("pre_write_rem", int'(rem_a), 9);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("relock_lock_a", int'(lock_a), 1);
        check("relock_rem_a",  int'(rem_a),  0);
        check("open_lock_b",   int'(lock_b), 0);
        check("open_rem_b",    int'(rem_b),  8);
        idle(9);
        check("b_expired", int'(lock_b), 1);

        // Force lock wins over a simultaneous key write
        key(KEY0);
        key(KEY1);
        idle(3);
        step(1'b1, KEY0, 1'b0, 1'b1);
        check("force_lock", int'(lock_a), 1);
        check("force_err",  int'(err_a),  0);
        step(1'b1, KEY0, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        idle(1);

        // Asynchronous reset mid-window
        key(KEY0);
        key(KEY1);
        idle(4);
        #2 i_rst_n = 1'b0;
        #1;
        check("async_rst_lock_a", int'(lock_a), 1);
        check("async_rst_lock_b", int'(lock_b), 1);
        check("async_rst_rem",    int'(rem_a),  0);
        model_reset();
        #2 i_rst_n = 1'b1;
        idle(2);
        key(KEY0);
        key(KEY1);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
